// File: rtl/mdu_alu_ctrl.sv
// rtl/mdu_alu_ctrl.sv - ALU control decode, single-cycle ALU and iterative multiply/divide unit
module mdu_alu_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [1:0]       aluop,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [3:0]       alucontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_nxt;

  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   acc, q, m, dvd;
  logic               neg_q, neg_r, div0;
  logic               accept, is_mul, is_div, is_sgn, last;
  logic               a_neg, b_neg, div_ge;
  logic [WIDTH-1:0]   abs_a, abs_b, alu_res;
  logic [WIDTH-1:0]   acc_nxt, q_nxt, fin_hi, fin_lo;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    alucontrol = 4'b0001;
    if (aluop == 2'b00) alucontrol = 4'b0010;
    else if (aluop == 2'b01) alucontrol = 4'b0110;
    else begin
      case (func)
        6'b100000: alucontrol = 4'b0010;
        6'b000000: alucontrol = 4'b1010;
        6'b000010: alucontrol = 4'b1100;
        6'b100010: alucontrol = 4'b0110;
        6'b100100: alucontrol = 4'b0000;
        6'b100101: alucontrol = 4'b0001;
        6'b101011: alucontrol = 4'b0111;
        6'b011000, 6'b011001, 6'b011010, 6'b011011,
        6'b010000, 6'b010010: alucontrol = 4'b1000;
        default:   alucontrol = 4'b0001;
      endcase
    end
  end

  assign accept = valid && ready;
  assign is_mul = aluop[1] && (func[5:1] == 5'b01100);
  assign is_div = aluop[1] && (func[5:1] == 5'b01101);
  assign is_sgn = ~func[0];
  assign last   = (cnt == SHW'(WIDTH - 1));
  assign a_neg  = is_sgn && a[WIDTH-1];
  assign b_neg  = is_sgn && b[WIDTH-1];
  assign abs_a  = a_neg ? -a : a;
  assign abs_b  = b_neg ? -b : b;

  // Shifts operate on b (the rt operand), matching the usual sll/srl encoding
  always_comb begin
    alu_res = a | b;
    case (alucontrol)
      4'b0010: alu_res = a + b;
      4'b0110: alu_res = a - b;
      4'b1010: alu_res = b << shamt;
      4'b1100: alu_res = b >> shamt;
      4'b0000: alu_res = a & b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1000: alu_res = (func == 6'b010000) ? hi : lo;
      default: alu_res = a | b;
    endcase
  end

  // One iteration per cycle on magnitudes; sign is restored in the completion cycle
  always_comb begin
    mul_sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    div_sh  = {acc, q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, m});
    if (state == MUL) begin
      acc_nxt = mul_sum[WIDTH:1];
      q_nxt   = {mul_sum[0], q[WIDTH-1:1]};
    end else begin
      acc_nxt = div_ge ? (div_sh[WIDTH-1:0] - m) : div_sh[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], div_ge};
    end
    prod = neg_q ? -{acc_nxt, q_nxt} : {acc_nxt, q_nxt};
    if (state == MUL) begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (div0) begin
      fin_hi = dvd;
      fin_lo = '1;
    end else begin
      fin_hi = neg_r ? -acc_nxt : acc_nxt;
      fin_lo = neg_q ? -q_nxt : q_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_nxt = MUL;
        else if (accept && is_div) state_nxt = DIV;
      end
      MUL, DIV: if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      dvd    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      ready  <= 1'b1;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (accept && is_mul) begin
          acc   <= '0;
          q     <= abs_b;
          m     <= abs_a;
          neg_q <= a_neg ^ b_neg;
          cnt   <= '0;
          ready <= 1'b0;
        end else if (accept && is_div) begin
          acc   <= '0;
          q     <= abs_a;
          m     <= abs_b;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          div0  <= (b == '0);
          dvd   <= a;
          cnt   <= '0;
          ready <= 1'b0;
        end else if (accept) begin
          result <= alu_res;
          zero   <= (alu_res == '0);
          done   <= 1'b1;
        end
      end else begin
        acc <= acc_nxt;
        q   <= q_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          hi     <= fin_hi;
          lo     <= fin_lo;
          result <= fin_lo;
          zero   <= (fin_lo == '0);
          done   <= 1'b1;
          ready  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdu_alu_ctrl.sv
// tb/tb_mdu_alu_ctrl.sv - randomized self-checking bench for mdu_alu_ctrl against a reference model
module tb_mdu_alu_ctrl;
  logic        clk = 1'b0, reset = 1'b0, valid = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic [5:0]  func = 6'b0;
  logic [31:0] a = 32'h0, b = 32'h0;
  logic [4:0]  shamt = 5'h0;
  logic [3:0]  alucontrol;
  logic [31:0] result, hi, lo;
  logic        zero, ready, done;

  int vecs = 0, errs = 0;
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0;

  always #5 clk = ~clk;

  mdu_alu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid(valid), .aluop(aluop), .func(func),
    .a(a), .b(b), .shamt(shamt), .alucontrol(alucontrol), .result(result),
    .zero(zero), .ready(ready), .done(done), .hi(hi), .lo(lo)
  );

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    case (f)
      6'b100000: return 4'b0010;
      6'b000000: return 4'b1010;
      6'b000010: return 4'b1100;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101011: return 4'b0111;
      6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010: return 4'b1000;
      default:   return 4'b0001;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                          input logic [31:0] x, y, input logic [4:0] sh);
    if (op == 2'b00) return x + y;
    if (op == 2'b01) return x - y;
    case (f)
      6'b100000: return x + y;
      6'b000000: return y << sh;
      6'b000010: return y >> sh;
      6'b100010: return x - y;
      6'b100100: return x & y;
      6'b101011: return (x < y) ? 32'd1 : 32'd0;
      6'b010000: return m_hi;
      6'b010010: return m_lo;
      default:   return x | y;
    endcase
  endfunction

  task automatic ref_mdu(input logic [5:0] f, input logic [31:0] x, y,
                         output logic [31:0] rh, output logic [31:0] rl);
    longint      p;
    logic [63:0] up;
    int          sx, sy;
    sx = x;
    sy = y;
    if (f == 6'b011000) begin
      p = longint'($signed(x)) * longint'($signed(y));
      {rh, rl} = p;
    end else if (f == 6'b011001) begin
      up = {32'h0, x} * {32'h0, y};
      {rh, rl} = up;
    end else if (y == 32'h0) begin
      rl = 32'hFFFFFFFF;
      rh = x;
    end else if (f == 6'b011010 && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
      rl = 32'h80000000;
      rh = 32'h0;
    end else if (f == 6'b011010) begin
      rl = sx / sy;
      rh = sx % sy;
    end else begin
      rl = x / y;
      rh = x % y;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x, y,
                      input logic [4:0] sh);
    @(negedge clk);
    valid = 1'b1; aluop = op; func = f; a = x; b = y; shamt = sh;
    @(negedge clk);
    valid = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    #12;
    vecs++; if (result !== 32'h0) begin errs++; $display("FAIL rst_result got=%h exp=%h", result, 32'h0); end
    vecs++; if (zero !== 1'b1) begin errs++; $display("FAIL rst_zero got=%b exp=1", zero); end
    vecs++; if (hi !== 32'h0 || lo !== 32'h0) begin errs++; $display("FAIL rst_hilo got=%h/%h exp=0/0", hi, lo); end
    vecs++; if (done !== 1'b0 || ready !== 1'b1) begin errs++; $display("FAIL rst_hs got done=%b ready=%b exp 0/1", done, ready); end
    aluop = 2'b10; func = 6'b100010; #1;
    vecs++; if (alucontrol !== 4'b0110) begin errs++; $display("FAIL rst_ctrl got=%b exp=0110", alucontrol); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_decode;
    logic [31:0] x, y;
    for (int f = 0; f < 64; f++) begin
      @(negedge clk); aluop = 2'b10; func = 6'(f); #1;
      vecs++; if (alucontrol !== ref_ctrl(2'b10, 6'(f))) begin errs++; $display("FAIL ctrl_f%0d got=%b exp=%b", f, alucontrol, ref_ctrl(2'b10, 6'(f))); end
    end
    for (int op = 0; op < 4; op++) begin
      aluop = 2'(op); func = 6'($urandom); #1;
      vecs++; if (alucontrol !== ref_ctrl(2'(op), func)) begin errs++; $display("FAIL ctrl_op%0d got=%b exp=%b", op, alucontrol, ref_ctrl(2'(op), func)); end
    end
    for (int f = 0; f < 64; f++) begin
      if (ref_ctrl(2'b10, 6'(f)) == 4'b0001) begin
        x = $urandom; y = $urandom;
        send(2'b10, 6'(f), x, y, 5'($urandom));
        vecs++; if (done !== 1'b1 || result !== (x | y)) begin errs++; $display("FAIL unlisted_f%0d got=%h done=%b exp=%h", f, result, done, x | y); end
      end
    end
  endtask

  task automatic test_single;
    logic [1:0] op; logic [5:0] f; logic [31:0] x, y, e; logic [4:0] sh;
    send(2'b10, 6'b100010, 32'd5, 32'd7, 5'd0);
    vecs++; if (result !== 32'hFFFFFFFE || done !== 1'b1 || zero !== 1'b0 || ready !== 1'b1) begin
      errs++; $display("FAIL sub_5_7 got=%h d=%b z=%b r=%b exp=fffffffe 1 0 1", result, done, zero, ready); end
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); f = 6'($urandom);
      if (op[1] && (f[5:1] == 5'b01100 || f[5:1] == 5'b01101)) f = 6'b100100;
      x = $urandom; y = (i % 5 == 0) ? x : $urandom; sh = 5'($urandom);
      e = ref_alu(op, f, x, y, sh);
      send(op, f, x, y, sh);
      vecs++; if (done !== 1'b1) begin errs++; $display("FAIL single_done%0d got=%b exp=1", i, done); end
      vecs++; if (result !== e) begin errs++; $display("FAIL single_res%0d op=%b f=%b got=%h exp=%h", i, op, f, result, e); end
      vecs++; if (zero !== (e == 32'h0)) begin errs++; $display("FAIL single_zero%0d got=%b exp=%b", i, zero, e == 32'h0); end
      vecs++; if (hi !== m_hi || lo !== m_lo || ready !== 1'b1) begin errs++; $display("FAIL single_hilo%0d got=%h/%h r=%b exp=%h/%h 1", i, hi, lo, ready, m_hi, m_lo); end
      @(negedge clk);
      vecs++; if (done !== 1'b0 || result !== e) begin errs++; $display("FAIL single_hold%0d got done=%b res=%h exp 0 %h", i, done, result, e); end
    end
  endtask

  task automatic test_mdu;
    logic [5:0] fl[5] = '{6'b011000, 6'b011010, 6'b011011, 6'b011010, 6'b011010};
    logic [31:0] xl[5] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFF3};
    logic [31:0] yl[5] = '{32'd3, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [5:0] f; logic [31:0] x, y, eh, el; int n;
    for (int i = 0; i < 25; i++) begin
      if (i < 5) begin f = fl[i]; x = xl[i]; y = yl[i]; end
      else begin
        f = {4'b0110, 2'($urandom)}; x = $urandom;
        y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      end
      ref_mdu(f, x, y, eh, el);
      send(2'b10, f, x, y, 5'($urandom));
      vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL mdu_busy%0d got ready=%b exp=0", i, ready); end
      wait_done(n);
      vecs++; if (n != 33) begin errs++; $display("FAIL mdu_lat%0d got=%0d exp=33", i, n); end
      vecs++; if (hi !== eh || lo !== el) begin errs++; $display("FAIL mdu_hilo%0d f=%b a=%h b=%h got=%h/%h exp=%h/%h", i, f, x, y, hi, lo, eh, el); end
      vecs++; if (result !== el || zero !== (el == 32'h0) || ready !== 1'b1) begin
        errs++; $display("FAIL mdu_res%0d got=%h z=%b r=%b exp=%h %b 1", i, result, zero, ready, el, el == 32'h0); end
      m_hi = eh; m_lo = el;
      send(2'b10, (i % 2) ? 6'b010010 : 6'b010000, $urandom, $urandom, 5'd0);
      vecs++; if (result !== ((i % 2) ? m_lo : m_hi) || done !== 1'b1) begin
        errs++; $display("FAIL mf%0d got=%h exp=%h", i, result, (i % 2) ? m_lo : m_hi); end
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] fl[2] = '{6'b011000, 6'b011010};
    logic [5:0] ml[2] = '{6'b010000, 6'b010010};
    logic [31:0] xl[2] = '{32'hFFFFFFFF, 32'h80000000};
    logic [31:0] yl[2] = '{32'd3, 32'hFFFFFFFF};
    logic [31:0] held, eh, el, em; int n, bad;
    send(2'b00, 6'b0, 32'h1234, 32'h1, 5'd0);
    held = 32'h1235;
    for (int k = 0; k < 2; k++) begin
      ref_mdu(fl[k], xl[k], yl[k], eh, el);
      @(negedge clk); valid = 1'b1; aluop = 2'b10; func = fl[k]; a = xl[k]; b = yl[k];
      @(negedge clk); func = ml[k]; a = $urandom; b = $urandom;
      n = 1; bad = 0;
      while (done !== 1'b1 && n < 100) begin
        if (result !== held) bad++;
        @(negedge clk); n++;
      end
      vecs++; if (bad != 0) begin errs++; $display("FAIL b2b_held%0d got=%0d changes exp=0", k, bad); end
      vecs++; if (n != 33 || ready !== 1'b1) begin errs++; $display("FAIL b2b_lat%0d got=%0d r=%b exp=33 1", k, n, ready); end
      vecs++; if (hi !== eh || lo !== el) begin errs++; $display("FAIL b2b_hilo%0d got=%h/%h exp=%h/%h", k, hi, lo, eh, el); end
      m_hi = eh; m_lo = el;
      em = (k == 0) ? m_hi : m_lo;
      @(negedge clk); valid = 1'b0;
      vecs++; if (done !== 1'b1 || result !== em) begin errs++; $display("FAIL b2b_mf%0d got=%h d=%b exp=%h 1", k, result, done, em); end
      held = em;
    end
  endtask

  task automatic test_reset_abort;
    int pulses;
    @(negedge clk); valid = 1'b1; aluop = 2'b10; func = 6'b011011; a = $urandom; b = $urandom | 32'h1;
    @(negedge clk); valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0; #1;
    vecs++; if (hi !== 32'h0 || lo !== 32'h0) begin errs++; $display("FAIL abort_hilo got=%h/%h exp=0/0", hi, lo); end
    vecs++; if (ready !== 1'b1 || done !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
      errs++; $display("FAIL abort_outs got r=%b d=%b res=%h z=%b exp 1 0 0 1", ready, done, result, zero); end
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk); reset = 1'b1;
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) pulses++; end
    vecs++; if (pulses != 0 || hi !== 32'h0 || lo !== 32'h0) begin errs++; $display("FAIL abort_nodone got=%0d pulses hi/lo=%h/%h exp=0 0/0", pulses, hi, lo); end
    send(2'b00, 6'b0, 32'h10, 32'h20, 5'd0);
    vecs++; if (done !== 1'b1 || result !== 32'h30) begin errs++; $display("FAIL abort_accept got d=%b res=%h exp 1 30", done, result); end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_single;
    test_mdu;
    test_back_to_back;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=expired exp=finish");
    $fatal(1, "timeout");
  end
endmodule
